// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the multi-port integer register file.
//   XLEN_DEF  : default data width
//   NREGS_DEF : default number of architectural registers (power of two)
//   AW_DEF    : register index width derived from NREGS_DEF
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write reservation bits used by issue for RAW hazard detection.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_rd_addr      : read-port addresses whose pending state is reported
//   o_rd_pending   : pending bit per read port (combinational)
//   i_wr_en/addr/clr : write ports; an enabled write with clr releases its register
//   i_rsv_en/addr  : reserve (mark pending) one register
//   i_flush        : drop every reservation
//   o_busy_count   : registered number of pending registers
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NRD-1:0][AW-1:0]   i_rd_addr,
  output logic [NRD-1:0]           o_rd_pending,
  input  logic [NWR-1:0]           i_wr_en,
  input  logic [NWR-1:0][AW-1:0]   i_wr_addr,
  input  logic [NWR-1:0]           i_wr_clr,
  input  logic                     i_rsv_en,
  input  logic [AW-1:0]            i_rsv_addr,
  input  logic                     i_flush,
  output logic [AW-1:0]            o_busy_count
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_clr_mask;
  logic [AW-1:0]    r_busy;
  logic [AW-1:0]    w_busy_nxt;

  // Registers released by a clearing write this cycle; x0 is never pending.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NWR; i++) begin
      if (i_wr_en[i] && i_wr_clr[i]) w_clr[i_wr_addr[i]] = 1'b1;
    end
    w_clr[0] = 1'b0;
  end

  // Priority: flush, then reserve, then clear, else hold.
  always_comb begin
    w_pending_nxt = r_pending & ~w_clr;
    if (i_rsv_en) w_pending_nxt[i_rsv_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
    if (i_flush) w_pending_nxt = '0;
  end

  // Count at most NREGS-1 bits, so the sum always fits in AW bits.
  always_comb begin
    w_busy_nxt = '0;
    for (int r = 1; r < NREGS; r++) begin
      w_busy_nxt = w_busy_nxt + AW'(w_pending_nxt[r]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      r_busy    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign w_clr_mask = (BYPASS != 0) ? w_clr : '0;

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      o_rd_pending[j] = r_pending[i_rd_addr[j]] & ~w_clr_mask[i_rd_addr[j]];
    end
  end

  assign o_busy_count = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with optional write-to-read bypass and
// an integrated pending-write scoreboard. x0 reads zero and is never pending.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_rd_addr/o_rd_data : NRD combinational read ports
//   o_rd_pending        : addressed register has an outstanding reservation
//   i_wr_en/addr/data   : NWR write ports, highest index wins on address collision
//   i_wr_clr            : write also releases the reservation of its register
//   i_rsv_en/addr       : reserve a register for an issuing instruction
//   i_flush             : clear all reservations
//   o_busy_count        : registered count of pending registers
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NRD-1:0][AW-1:0]   i_rd_addr,
  output logic [NRD-1:0][XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]           o_rd_pending,
  input  logic [NWR-1:0]           i_wr_en,
  input  logic [NWR-1:0][AW-1:0]   i_wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] i_wr_data,
  input  logic [NWR-1:0]           i_wr_clr,
  input  logic                     i_rsv_en,
  input  logic [AW-1:0]            i_rsv_addr,
  input  logic                     i_flush,
  output logic [AW-1:0]            o_busy_count
);

  logic [XLEN-1:0]  r_mem    [NREGS];
  logic [XLEN-1:0]  w_wr_val [NREGS];
  logic [NREGS-1:0] w_wr_hit;

  // Write arbitration: ascending port loop lets the highest index overwrite lower ones.
  always_comb begin
    w_wr_hit = '0;
    for (int r = 0; r < NREGS; r++) w_wr_val[r] = '0;
    for (int i = 0; i < NWR; i++) begin
      if (i_wr_en[i]) begin
        w_wr_hit[i_wr_addr[i]] = 1'b1;
        w_wr_val[i_wr_addr[i]] = i_wr_data[i];
      end
    end
    w_wr_hit[0] = 1'b0;
    w_wr_val[0] = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) r_mem[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w_wr_hit[r]) r_mem[r] <= w_wr_val[r];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      if (i_rd_addr[j] == '0) begin
        o_rd_data[j] = '0;
      end else if ((BYPASS != 0) && w_wr_hit[i_rd_addr[j]]) begin
        o_rd_data[j] = w_wr_val[i_rd_addr[j]];
      end else begin
        o_rd_data[j] = r_mem[i_rd_addr[j]];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rd_addr    (i_rd_addr),
    .o_rd_pending (o_rd_pending),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_clr     (i_wr_clr),
    .i_rsv_en     (i_rsv_en),
    .i_rsv_addr   (i_rsv_addr),
    .i_flush      (i_flush),
    .o_busy_count (o_busy_count)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench driving a bypassing and a non-bypassing register file
// with shared stimulus and comparing against hand-computed values.
module tb_regfile_mp;

  logic             clk;
  logic             rst_n;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0][31:0] rd_data_nb;
  logic [1:0]       rd_pend;
  logic [1:0]       rd_pend_nb;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0]       wr_clr;
  logic             rsv_en;
  logic [4:0]       rsv_addr;
  logic             flush;
  logic [4:0]       busy;
  logic [4:0]       busy_nb;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_mp #(.BYPASS(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_pending (rd_pend),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_wr_clr     (wr_clr),
    .i_rsv_en     (rsv_en),
    .i_rsv_addr   (rsv_addr),
    .i_flush      (flush),
    .o_busy_count (busy)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data_nb),
    .o_rd_pending (rd_pend_nb),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_wr_clr     (wr_clr),
    .i_rsv_en     (rsv_en),
    .i_rsv_addr   (rsv_addr),
    .i_flush      (flush),
    .o_busy_count (busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_clr   = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    flush    = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle_inputs();
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_x0", rd_data[0], 32'd0);
    rd_addr[1] = 5'd5;
    #1;
    chk("reset_x5", rd_data[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // x0 writes are discarded
    rd_addr    = '0;
    wr_en      = 2'b01;
    wr_addr[0] = 5'd0;
    wr_data[0] = 32'hDEADBEEF;
    #1;
    chk("x0_bypass", rd_data[0], 32'd0);
    step();
    idle_inputs();
    #1;
    chk("x0_after", rd_data[0], 32'd0);
    chk("x0_busy", 32'(busy), 32'd0);

    // Two ports collide on x5: port 1 wins
    rd_addr[0] = 5'd5;
    wr_en      = 2'b11;
    wr_addr[0] = 5'd5;
    wr_data[0] = 32'h1111;
    wr_addr[1] = 5'd5;
    wr_data[1] = 32'h2222;
    #1;
    chk("x5_byp", rd_data[0], 32'h2222);
    chk("x5_nobyp", rd_data_nb[0], 32'h0);
    step();
    idle_inputs();
    #1;
    chk("x5_next", rd_data[0], 32'h2222);
    chk("x5_next_nb", rd_data_nb[0], 32'h2222);

    // Reserve x7, then clearing write
    rd_addr  = {5'd7, 5'd7};
    rsv_en   = 1'b1;
    rsv_addr = 5'd7;
    #1;
    chk("x7_pend_early", 32'(rd_pend[1]), 32'd0);
    step();
    idle_inputs();
    #1;
    chk("x7_pend", 32'(rd_pend[1]), 32'd1);
    chk("x7_busy", 32'(busy), 32'd1);
    wr_en      = 2'b01;
    wr_addr[0] = 5'd7;
    wr_data[0] = 32'hA5A5;
    wr_clr     = 2'b01;
    #1;
    chk("x7_clr_byp_pend", 32'(rd_pend[1]), 32'd0);
    chk("x7_clr_byp_data", rd_data[0], 32'hA5A5);
    chk("x7_clr_nb_pend", 32'(rd_pend_nb[1]), 32'd1);
    chk("x7_clr_nb_data", rd_data_nb[0], 32'h0);
    chk("x7_clr_busy", 32'(busy), 32'd1);
    step();
    idle_inputs();
    #1;
    chk("x7_busy_after", 32'(busy), 32'd0);
    chk("x7_pend_after_nb", 32'(rd_pend_nb[1]), 32'd0);
    chk("x7_data_nb", rd_data_nb[0], 32'hA5A5);

    // Reserve beats same-cycle clear on x9
    rd_addr  = {5'd9, 5'd9};
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    step();
    idle_inputs();
    #1;
    chk("x9_pend", 32'(rd_pend[1]), 32'd1);
    rsv_en     = 1'b1;
    rsv_addr   = 5'd9;
    wr_en      = 2'b10;
    wr_addr[1] = 5'd9;
    wr_data[1] = 32'h9;
    wr_clr     = 2'b10;
    #1;
    chk("x9_mask_byp", 32'(rd_pend[1]), 32'd0);
    chk("x9_mask_nb", 32'(rd_pend_nb[1]), 32'd1);
    step();
    idle_inputs();
    #1;
    chk("x9_still_pend", 32'(rd_pend[1]), 32'd1);
    chk("x9_busy", 32'(busy), 32'd1);
    chk("x9_busy_nb", 32'(busy_nb), 32'd1);
    chk("x9_data", rd_data[0], 32'h9);
    wr_en      = 2'b01;
    wr_addr[0] = 5'd9;
    wr_data[0] = 32'h99;
    wr_clr     = 2'b01;
    step();
    idle_inputs();
    #1;
    chk("x9_released_busy", 32'(busy), 32'd0);

    // Fill the scoreboard, then flush with concurrent reserve and write
    for (int r = 1; r < 32; r++) begin
      rsv_en   = 1'b1;
      rsv_addr = 5'(r);
      step();
    end
    idle_inputs();
    rd_addr = {5'd3, 5'd0};
    #1;
    chk("full_busy", 32'(busy), 32'd31);
    chk("full_x3_pend", 32'(rd_pend[1]), 32'd1);
    chk("full_x0_pend", 32'(rd_pend[0]), 32'd0);
    flush      = 1'b1;
    rsv_en     = 1'b1;
    rsv_addr   = 5'd3;
    wr_en      = 2'b01;
    wr_addr[0] = 5'd3;
    wr_data[0] = 32'h3;
    step();
    idle_inputs();
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_busy_nb", 32'(busy_nb), 32'd0);
    chk("flush_x3_data", rd_data[1], 32'h3);
    chk("flush_x3_pend", 32'(rd_pend[1]), 32'd0);

    // Reset mid-cycle wipes data and reservations
    rd_addr  = {5'd4, 5'd4};
    rsv_en   = 1'b1;
    rsv_addr = 5'd4;
    step();
    idle_inputs();
    wr_en      = 2'b01;
    wr_addr[0] = 5'd4;
    wr_data[0] = 32'hFF;
    step();
    idle_inputs();
    #1;
    chk("x4_data", rd_data[0], 32'hFF);
    chk("x4_pend", 32'(rd_pend[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_x4_data", rd_data[0], 32'h0);
    chk("rst_x4_data_nb", rd_data_nb[0], 32'h0);
    chk("rst_x4_pend", 32'(rd_pend[0]), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, replacing the single-write, fixed-width register file. Provides NRD combinational read ports and NWR write ports, optional same-cycle write-to-read bypass, and an integrated pending-write scoreboard that the issue stage uses for RAW hazard detection. x0 is hardwired to zero and is never pending.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, read ports
- NWR, 2, write ports
- BYPASS, 1, 1 = same-cycle write data and pending-clear visible on read ports
- AW (derived), $clog2(NREGS), address width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×XLEN  read data, combinational
- rd_pending  out  NRD  addressed register has an outstanding reservation, combinational
- wr_en  in  NWR  write strobe per port
- wr_addr  in  NWR×AW  write address per port
- wr_data  in  NWR×XLEN  write data per port
- wr_clr  in  NWR  this write also clears the pending bit of wr_addr
- rsv_en  in  1  reserve (mark pending) rsv_addr
- rsv_addr  in  AW  register being reserved by the issuing instruction
- flush  in  1  clear all pending bits
- busy_count  out  AW  registered count of pending registers

## Operation
- Reset (async, rst_n=0): all registers 0, all pending bits 0, busy_count 0; rd_data reads 0 for every address.
- Writes: commit on rising clk where wr_en[i]=1 and wr_addr[i]≠0. Writes to x0 discarded, wr_clr to x0 ignored.
- Multiple write ports to same address in one cycle: highest port index wins data; any wr_clr on that address clears.
- Reads: rd_data[j] = 0 when rd_addr[j]=0; otherwise stored value. With BYPASS=1, a same-cycle enabled write to rd_addr[j] (≠0) is forwarded, highest port index winning; with BYPASS=0, the old value is returned.
- Scoreboard per register r≠0, next pending: flush → 0; else rsv_en && rsv_addr=r → 1 (reserve beats same-cycle clear); else any wr_en[i]&&wr_clr[i]&&wr_addr[i]=r → 0; else hold.
- rsv_en with rsv_addr=0 is a no-op. Reserving an already pending register keeps it pending (no count change).
- rd_pending[j]: registered pending bit of rd_addr[j]; with BYPASS=1, masked to 0 when a same-cycle clearing write targets that address; always 0 for x0.
- flush same cycle as writes: data writes still commit; all pending cleared; rsv_en discarded.
- busy_count = popcount of pending bits after each update; max NREGS-1, fits AW bits.

## Timing
- Read latency 0 (combinational from rd_addr, and from wr_* when BYPASS=1).
- Write latency 1: value visible on rd_data the cycle after the write edge (same cycle with BYPASS=1).
- Reservation visible on rd_pending the cycle after rsv_en edge; busy_count updates on the same edge.
- Reset deassertion takes effect at the next rising edge; assertion mid-operation clears all state immediately, including in-flight reservations.

## Structure
- Package regfile_pkg: XLEN default, NREGS default, AW computed via localparam, typedef for register index and data word.
- Sub-module regfile_scoreboard: pending-bit vector, flush/reserve/clear priority, busy_count; regfile_mp instantiates it and owns storage, write arbitration and bypass muxes.

## Test plan
- Reset then write 32'hDEADBEEF to x0 on port 0 -> rd_data for addr 0 reads 0, busy_count 0.
- Port 0 writes x5=32'h1111, port 1 writes x5=32'h2222 same cycle -> next cycle x5 reads 32'h2222; with BYPASS=1 same cycle already reads 32'h2222, BYPASS=0 reads prior 0.
- rsv_en x7 -> next cycle rd_pending=1, busy_count=1; write x7=32'hA5A5 with wr_clr -> BYPASS=1 same-cycle pending 0 and data 32'hA5A5; next cycle busy_count 0.
- Same cycle rsv_en x9 and clearing write to x9 (x9 pending) -> x9 stays pending, busy_count unchanged.
- Reserve x1..x31 over 31 cycles -> busy_count 31; flush with concurrent rsv_en x3 and write x3=32'h3 -> busy_count 0, x3 reads 32'h3, x3 not pending.
- Reserve x4, write x4=32'hFF, assert rst_n=0 mid-cycle -> immediately x4 reads 0, rd_pending 0, busy_count 0.
